// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate controller.
package parking_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPEN  = 2'd1,
        ST_CLOSE = 2'd2
    } gate_state_e;

    typedef enum logic {
        LANE_ENTRY = 1'b0,
        LANE_EXIT  = 1'b1
    } lane_e;

    localparam int STAT_W = 16;

    // Saturating increment for the statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + {{(STAT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/gate_rr_arb.sv
// Two-lane alternating arbiter; remembers the lane served last (entry after reset).
module gate_rr_arb
    import parking_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic entry_req,
    input  logic exit_req,
    input  logic commit,
    output logic win_valid,
    output logic win_lane
);

    logic last_r;

    // Pick the requesting lane; on a tie the lane not served last wins.
    always_comb begin
        win_valid = entry_req | exit_req;
        win_lane  = LANE_EXIT;
        if (entry_req && exit_req) begin
            win_lane = (last_r == LANE_EXIT) ? LANE_ENTRY : LANE_EXIT;
        end else if (entry_req) begin
            win_lane = LANE_ENTRY;
        end else begin
            win_lane = LANE_EXIT;
        end
    end

    // Last-served flag, updated whenever IDLE acts on a winner (grant or reject).
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r <= LANE_ENTRY;
        end else if (commit) begin
            last_r <= win_lane;
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking barrier controller: arbitrates entry/exit lanes, opens, times out and closes the gate.
// Optional statistics counters are enabled with the GATE_STATS_EN macro.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int TIMEOUT      = 16,
    parameter int CLOSE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic entry_req,
    input  logic entry_is_uni,
    input  logic exit_req,
    input  logic exit_is_uni,
    input  logic uni_is_vacated_space,
    input  logic is_vacated_space,
    input  logic car_passed,
    output logic car_entered,
    output logic is_uni_car_entered,
    output logic car_exited,
    output logic is_uni_car_exited,
    output logic gate_open,
    output logic entry_grant,
    output logic exit_grant,
    output logic entry_reject,
    output logic timeout,
    output logic busy
`ifdef GATE_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_entries,
    output logic [STAT_W-1:0] stat_exits,
    output logic [STAT_W-1:0] stat_rejects,
    output logic [STAT_W-1:0] stat_timeouts
`endif
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] CLOSE_LAST = TW'(CLOSE_CYCLES - 1);

    gate_state_e   state_r, state_s;
    logic [TW-1:0] timer_r, timer_s;
    lane_e         lane_r, lane_s;
    logic          uni_r, uni_s;
    logic          win_valid_s, win_lane_s, commit_s;
    logic          ce_s, uce_s, cx_s, ucx_s, eg_s, xg_s, rej_s, to_s;
    logic          ce_r, uce_r, cx_r, ucx_r, eg_r, xg_r, rej_r, to_r, gate_r, busy_r;

    gate_rr_arb u_arb (
        .clk       (clk),
        .rst       (rst),
        .entry_req (entry_req),
        .exit_req  (exit_req),
        .commit    (commit_s),
        .win_valid (win_valid_s),
        .win_lane  (win_lane_s)
    );

    // Next-state, timer and pulse decode; the timer doubles as the CLOSE hold counter.
    always_comb begin
        state_s  = state_r;
        timer_s  = timer_r;
        lane_s   = lane_r;
        uni_s    = uni_r;
        commit_s = 1'b0;
        ce_s = 1'b0; uce_s = 1'b0; cx_s = 1'b0; ucx_s = 1'b0;
        eg_s = 1'b0; xg_s  = 1'b0; rej_s = 1'b0; to_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                timer_s = {TW{1'b0}};
                if (win_valid_s) begin
                    commit_s = 1'b1;
                    if (win_lane_s == LANE_EXIT) begin
                        state_s = ST_OPEN;
                        lane_s  = LANE_EXIT;
                        uni_s   = exit_is_uni;
                        xg_s    = 1'b1;
                    end else if (entry_is_uni ? uni_is_vacated_space : is_vacated_space) begin
                        state_s = ST_OPEN;
                        lane_s  = LANE_ENTRY;
                        uni_s   = entry_is_uni;
                        eg_s    = 1'b1;
                    end else begin
                        rej_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_OPEN: begin
                if (car_passed) begin
                    state_s = ST_CLOSE;
                    timer_s = {TW{1'b0}};
                    if (lane_r == LANE_ENTRY) begin
                        ce_s  = 1'b1;
                        uce_s = uni_r;
                    end else begin
                        cx_s  = 1'b1;
                        ucx_s = uni_r;
                    end
                end else if (timer_r == TIMER_LAST) begin
                    state_s = ST_CLOSE;
                    timer_s = {TW{1'b0}};
                    to_s    = 1'b1;
                end else begin
                    timer_s = timer_r + {{(TW-1){1'b0}}, 1'b1};
                end
            end
            ST_CLOSE: begin
                if (timer_r == CLOSE_LAST) begin
                    state_s = ST_IDLE;
                    timer_s = {TW{1'b0}};
                end else begin
                    timer_s = timer_r + {{(TW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = ST_IDLE;
                timer_s = {TW{1'b0}};
            end
        endcase
    end

    // State, capture and registered outputs; reset aborts any service silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            timer_r <= {TW{1'b0}};
            lane_r  <= LANE_ENTRY;
            uni_r   <= 1'b0;
            ce_r <= 1'b0; uce_r <= 1'b0; cx_r <= 1'b0; ucx_r <= 1'b0;
            eg_r <= 1'b0; xg_r  <= 1'b0; rej_r <= 1'b0; to_r <= 1'b0;
            gate_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            state_r <= state_s;
            timer_r <= timer_s;
            lane_r  <= lane_s;
            uni_r   <= uni_s;
            ce_r <= ce_s; uce_r <= uce_s; cx_r <= cx_s; ucx_r <= ucx_s;
            eg_r <= eg_s; xg_r  <= xg_s;  rej_r <= rej_s; to_r <= to_s;
            gate_r <= (state_s == ST_OPEN);
            busy_r <= (state_s != ST_IDLE);
        end
    end

    assign car_entered        = ce_r;
    assign is_uni_car_entered = uce_r;
    assign car_exited         = cx_r;
    assign is_uni_car_exited  = ucx_r;
    assign gate_open          = gate_r;
    assign entry_grant        = eg_r;
    assign exit_grant         = xg_r;
    assign entry_reject       = rej_r;
    assign timeout            = to_r;
    assign busy               = busy_r;

`ifdef GATE_STATS_EN
    logic [STAT_W-1:0] st_ent_r, st_ext_r, st_rej_r, st_to_r;

    // Counters step on the same edge that raises their pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_ent_r <= {STAT_W{1'b0}};
            st_ext_r <= {STAT_W{1'b0}};
            st_rej_r <= {STAT_W{1'b0}};
            st_to_r  <= {STAT_W{1'b0}};
        end else begin
            st_ent_r <= ce_s  ? sat_inc(st_ent_r) : st_ent_r;
            st_ext_r <= cx_s  ? sat_inc(st_ext_r) : st_ext_r;
            st_rej_r <= rej_s ? sat_inc(st_rej_r) : st_rej_r;
            st_to_r  <= to_s  ? sat_inc(st_to_r)  : st_to_r;
        end
    end

    assign stat_entries  = st_ent_r;
    assign stat_exits    = st_ext_r;
    assign stat_rejects  = st_rej_r;
    assign stat_timeouts = st_to_r;
`endif

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed, table-driven bench for parking_gate_ctrl (default parameters).
module tb_parking_gate_ctrl;
    import parking_pkg::*;

    logic clk = 1'b0;
    logic rst, entry_req, entry_is_uni, exit_req, exit_is_uni;
    logic uni_is_vacated_space, is_vacated_space, car_passed;
    logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
    logic gate_open, entry_grant, exit_grant, entry_reject, timeout, busy;
`ifdef GATE_STATS_EN
    logic [STAT_W-1:0] stat_entries, stat_exits, stat_rejects, stat_timeouts;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    parking_gate_ctrl #(.TIMEOUT(16), .CLOSE_CYCLES(2)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .entry_req            (entry_req),
        .entry_is_uni         (entry_is_uni),
        .exit_req             (exit_req),
        .exit_is_uni          (exit_is_uni),
        .uni_is_vacated_space (uni_is_vacated_space),
        .is_vacated_space     (is_vacated_space),
        .car_passed           (car_passed),
        .car_entered          (car_entered),
        .is_uni_car_entered   (is_uni_car_entered),
        .car_exited           (car_exited),
        .is_uni_car_exited    (is_uni_car_exited),
        .gate_open            (gate_open),
        .entry_grant          (entry_grant),
        .exit_grant           (exit_grant),
        .entry_reject         (entry_reject),
        .timeout              (timeout),
        .busy                 (busy)
`ifdef GATE_STATS_EN
        ,
        .stat_entries         (stat_entries),
        .stat_exits           (stat_exits),
        .stat_rejects         (stat_rejects),
        .stat_timeouts        (stat_timeouts)
`endif
    );

    // Inputs: {rst, entry_req, entry_is_uni, exit_req, exit_is_uni, uni_space, space, car_passed}
    // Outputs: {gate_open, busy, entry_grant, exit_grant, entry_reject, timeout,
    //           car_entered, is_uni_car_entered, car_exited, is_uni_car_exited}
    typedef struct {
        logic [7:0] in;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[25];

    task automatic drive(input logic [7:0] v);
        {rst, entry_req, entry_is_uni, exit_req, exit_is_uni,
         uni_is_vacated_space, is_vacated_space, car_passed} = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [9:0] exp);
        logic [9:0] act;
        act = {gate_open, busy, entry_grant, exit_grant, entry_reject, timeout,
               car_entered, is_uni_car_entered, car_exited, is_uni_car_exited};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{8'b10000000, 10'b0000000000};
        vecs[1]  = '{8'b11010010, 10'b0000000000};
        vecs[2]  = '{8'b01010010, 10'b1101000000};
        vecs[3]  = '{8'b01010011, 10'b0100000010};
        vecs[4]  = '{8'b01010010, 10'b0100000000};
        vecs[5]  = '{8'b01010010, 10'b0000000000};
        vecs[6]  = '{8'b01010010, 10'b1110000000};
        vecs[7]  = '{8'b01010011, 10'b0100001000};
        vecs[8]  = '{8'b01010010, 10'b0100000000};
        vecs[9]  = '{8'b00000000, 10'b0000000000};
        vecs[10] = '{8'b01000100, 10'b0000100000};
        vecs[11] = '{8'b00000000, 10'b0000000000};
        vecs[12] = '{8'b01011000, 10'b1101000000};
        vecs[13] = '{8'b00000001, 10'b0100000011};
        vecs[14] = '{8'b00000000, 10'b0100000000};
        vecs[15] = '{8'b00000000, 10'b0000000000};
        vecs[16] = '{8'b01100100, 10'b1110000000};
        vecs[17] = '{8'b00000000, 10'b1100000000};
        vecs[18] = '{8'b00000000, 10'b1100000000};
        vecs[19] = '{8'b00000001, 10'b0100001100};
        vecs[20] = '{8'b00000000, 10'b0100000000};
        vecs[21] = '{8'b00000000, 10'b0000000000};
        vecs[22] = '{8'b00000001, 10'b0000000000};
        vecs[23] = '{8'b01100010, 10'b0000100000};
        vecs[24] = '{8'b00000000, 10'b0000000000};

        drive(8'b10000000);
        tick();
        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].in);
            tick();
            check($sformatf("row%0d", i), vecs[i].exp);
        end

        // Timeout: no car for the whole open window.
        drive(8'b00010000);
        tick();
        check("to_grant", 10'b1101000000);
        drive(8'b00000000);
        for (int i = 1; i < 16; i++) begin
            tick();
            check($sformatf("to_open%0d", i), 10'b1100000000);
        end
        tick();
        check("to_pulse", 10'b0100010000);
        tick();
        tick();
        check("to_idle", 10'b0000000000);

        // Collision: car_passed on the last open cycle beats the timeout.
        drive(8'b00010000);
        tick();
        check("col_grant", 10'b1101000000);
        drive(8'b00000000);
        for (int i = 1; i < 16; i++) begin
            tick();
            check($sformatf("col_open%0d", i), 10'b1100000000);
        end
        drive(8'b00000001);
        tick();
        check("col_pass", 10'b0100000010);
        drive(8'b00000000);
        tick();
        tick();
        check("col_idle", 10'b0000000000);

        // Reset while the gate is open.
        drive(8'b01000010);
        tick();
        check("rst_grant", 10'b1110000000);
        drive(8'b00000000);
        tick();
        check("rst_open", 10'b1100000000);
        drive(8'b10000001);
        tick();
        check("rst_abort", 10'b0000000000);
`ifdef GATE_STATS_EN
        n_checks++;
        if ({stat_entries, stat_exits, stat_rejects, stat_timeouts} !== {(4*STAT_W){1'b0}}) begin
            n_fail++;
            $display("FAIL rst_stats: got %h %h %h %h expected all 0",
                     stat_entries, stat_exits, stat_rejects, stat_timeouts);
        end
`endif
        drive(8'b00000001);
        tick();
        check("rst_after", 10'b0000000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
